// File: rtl/byte_serial_multiplier.sv
// RV32M MUL/MULH/MULHSU/MULHU using Horner accumulation over operand B, one byte per cycle, MSB byte first.
// Latency: result valid 4 edges after the accepting edge. Backpressure: the result is held in DONE until ready_i is high.
module byte_serial_multiplier (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic [1:0]  funct_i,
    output logic [31:0] rot_operand_o,
    output logic [1:0]  rol_amount_o,
    input  logic [31:0] rot_result_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] F_MUL    = 2'b00;
    localparam logic [1:0] F_MULH   = 2'b01;
    localparam logic [1:0] F_MULHSU = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [1:0]  funct_q, funct_d;
    logic [31:0] result_q, result_d;

    logic               a_signed;
    logic               byte_signed;
    logic [7:0]         mul_byte;
    logic signed [32:0] a_ext;
    logic signed [8:0]  byte_ext;
    logic signed [41:0] prod;
    logic [63:0]        acc_next;
    logic               unused_rot_bits;

    // Only the top byte of the rotated word is the current multiplier byte.
    assign mul_byte        = rot_result_i[31:24];
    assign unused_rot_bits = ^rot_result_i[23:0];

    assign a_signed    = (funct_q == F_MULH) || (funct_q == F_MULHSU);
    // Only B's top byte carries the sign, and only for MULH.
    assign byte_signed = (cnt_q == 2'd0) && (funct_q == F_MULH);
    assign a_ext       = $signed({a_signed & a_q[31], a_q});
    assign byte_ext    = $signed({byte_signed & mul_byte[7], mul_byte});
    assign prod        = a_ext * byte_ext;
    assign acc_next    = (acc_q << 8) + {{22{prod[41]}}, prod};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        funct_d  = funct_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = op_a_i;
                    b_d     = op_b_i;
                    funct_d = funct_i;
                    acc_d   = 64'd0;
                    cnt_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    result_d = (funct_q == F_MUL) ? acc_next[31:0] : acc_next[63:32];
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            acc_q    <= 64'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            funct_q  <= 2'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            funct_q  <= funct_d;
            result_q <= result_d;
        end
    end

    assign ready_o       = (state_q == IDLE);
    assign valid_o       = (state_q == DONE);
    assign rol_amount_o  = (state_q == BUSY) ? cnt_q : 2'd0;
    assign rot_operand_o = b_q;
    assign result_o      = result_q;

endmodule

// File: tb/tb_byte_serial_multiplier.sv
// Bench for byte_serial_multiplier: directed vectors, expected results queued at issue and checked by a monitor.
module tb_byte_serial_multiplier;

    logic        clk_i;
    logic        rst_n_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic [1:0]  funct_i;
    logic [31:0] rot_operand_o;
    logic [1:0]  rol_amount_o;
    logic [31:0] rot_result_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    int          total;
    int          bad;
    logic [31:0] exp_q[$];

    byte_serial_multiplier dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .funct_i      (funct_i),
        .rot_operand_o(rot_operand_o),
        .rol_amount_o (rol_amount_o),
        .rot_result_i (rot_result_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stand-in for the byte rotator stage.
    always_comb begin
        case (rol_amount_o)
            2'd0:    rot_result_i = rot_operand_o;
            2'd1:    rot_result_i = {rot_operand_o[23:0], rot_operand_o[31:24]};
            2'd2:    rot_result_i = {rot_operand_o[15:0], rot_operand_o[31:16]};
            default: rot_result_i = {rot_operand_o[7:0],  rot_operand_o[31:8]};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every cycle a result is presented it must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_n_i && valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    check("result", result_o, exp_q[0]);
                    if (ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                         input logic [31:0] exp, input bit push);
        int n;
        n = 0;
        while (!ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!ready_o) check("ready_timeout", 32'd0, 32'd1);
        if (push) exp_q.push_back(exp);
        valid_i = 1'b1;
        op_a_i  = a;
        op_b_i  = b;
        funct_i = f;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        op_a_i  = 32'hxxxx_xxxx;
        op_b_i  = 32'hxxxx_xxxx;
    endtask

    // Called right after the accepting edge: rotate amounts 0..3, then valid after the 4th edge.
    task automatic check_latency();
        check("rol_amount_0", {30'd0, rol_amount_o}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk_i); #1;
            check("busy_no_valid", {31'd0, valid_o}, 32'd0);
            check("rol_amount", {30'd0, rol_amount_o}, i);
        end
        @(posedge clk_i); #1;
        check("latency_valid", {31'd0, valid_o}, 32'd1);
        check("rol_amount_done", {30'd0, rol_amount_o}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !ready_o) && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("drain_timeout", {31'd0, ready_o}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   {31'd0, ready_o}, 32'd1);
        check({tag, "_valid"},   {31'd0, valid_o}, 32'd0);
        check({tag, "_result"},  result_o, 32'd0);
        check({tag, "_operand"}, rot_operand_o, 32'd0);
        check({tag, "_rol"},     {30'd0, rol_amount_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        op_a_i  = 32'd0;
        op_b_i  = 32'd0;
        funct_i = 2'd0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        issue(32'd7, 32'd6, 2'b00, 32'h0000_002A, 1'b1);
        check_latency();
        drain();

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 1'b1);
        issue(32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 1'b1);
        issue(32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 32'hFFFF_FFFF, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 1'b1);
        issue(32'h0000_0002, 32'h8000_0000, 2'b10, 32'h0000_0001, 1'b1);
        issue(32'hFFFF_FFFE, 32'h0000_0003, 2'b01, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Backpressure: result and valid held while ready_i is low.
        ready_i = 1'b0;
        issue(32'h1234_5678, 32'h0000_0100, 2'b11, 32'h0000_0012, 1'b1);
        n = 0;
        while (!valid_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("bp_valid_rise", {31'd0, valid_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            check("bp_valid_held", {31'd0, valid_o}, 32'd1);
            check("bp_result_held", result_o, 32'h0000_0012);
            check("bp_no_ready", {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        drain();

        // A request raised while busy must not be taken or disturb the result.
        issue(32'h0000_0010, 32'h0000_0020, 2'b00, 32'h0000_0200, 1'b1);
        valid_i = 1'b1;
        op_a_i  = 32'hDEAD_BEEF;
        op_b_i  = 32'hCAFE_F00D;
        funct_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            check("busy_ready_low", {31'd0, ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        check("busy_operand_kept", rot_operand_o, 32'h0000_0020);
        drain();

        // Reset in the middle of an operation discards it.
        issue(32'h1111_1111, 32'h0000_0009, 2'b00, 32'd0, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("pre_reset_rol", {30'd0, rol_amount_o}, 32'd2);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            check("reset_no_valid", {31'd0, valid_o}, 32'd0);
        end
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        issue(32'd3, 32'd5, 2'b00, 32'h0000_000F, 1'b1);
        check_latency();
        drain();
        check("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
